// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised raster timing generator.
//
// Produces hsync/vsync, an active-video flag, visible-area coordinates and
// line/frame start strobes from free-running horizontal and vertical counters.
// Line layout is front porch, sync, back porch, active; the frame uses the
// same order counted in lines. The counters advance only on pix_en cycles,
// so pixel replication or slower pixel rates come from gating pix_en.
// Every output is registered from the pre-increment counter values, which
// gives one cycle of latency and keeps all outputs mutually aligned.
//
// Ports:
//   px_clk       in   pixel clock
//   reset        in   synchronous, active-high reset
//   pix_en       in   counter advance enable
//   hsync        out  horizontal sync, asserted level = H_POL
//   vsync        out  vertical sync, asserted level = V_POL
//   activevideo  out  high inside the visible region
//   x_px         out  visible column, 0 outside the visible region
//   y_px         out  visible row, 0 outside the visible region
//   line_start   out  one-cycle pulse for hc==0
//   frame_start  out  one-cycle pulse for hc==0 && vc==0
//   frame_cnt    out  16-bit wrapping frame counter (only with VGA_FRAME_COUNT_EN)
//
// Build option: define VGA_FRAME_COUNT_EN to add the frame_cnt output.
module vga_timing_gen #(
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 128,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic          px_clk,
  input  logic          reset,
  input  logic          pix_en,
`ifdef VGA_FRAME_COUNT_EN
  output logic [15:0]   frame_cnt,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          activevideo,
  output logic [CW-1:0] x_px,
  output logic [CW-1:0] y_px,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;

  // Boundaries pre-sized to the counter width so compares stay width-clean.
  localparam logic [CW-1:0] C_H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] C_H_SS   = CW'(H_FP);
  localparam logic [CW-1:0] C_H_SE   = CW'(H_FP + H_SYNC);
  localparam logic [CW-1:0] C_H_BL   = CW'(H_BLANK);
  localparam logic [CW-1:0] C_V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] C_V_SS   = CW'(V_FP);
  localparam logic [CW-1:0] C_V_SE   = CW'(V_FP + V_SYNC);
  localparam logic [CW-1:0] C_V_BL   = CW'(V_BLANK);

  logic [CW-1:0] r_hc, r_vc;
  logic [CW-1:0] w_hc_nxt, w_vc_nxt;
  logic          w_h_last, w_h_sync, w_v_sync, w_active, w_line0, w_frame0;

  logic          r_hsync, r_vsync, r_active, r_ls, r_fs;
  logic [CW-1:0] r_x, r_y;

  always_comb begin
    w_h_last = (r_hc == C_H_LAST);
    w_hc_nxt = w_h_last ? '0 : r_hc + 1'b1;
    w_vc_nxt = r_vc;
    if (w_h_last)
      w_vc_nxt = (r_vc == C_V_LAST) ? '0 : r_vc + 1'b1;
    w_h_sync = (r_hc >= C_H_SS) && (r_hc < C_H_SE);
    w_v_sync = (r_vc >= C_V_SS) && (r_vc < C_V_SE);
    w_active = (r_hc >= C_H_BL) && (r_vc >= C_V_BL);
    w_line0  = (r_hc == '0);
    w_frame0 = w_line0 && (r_vc == '0);
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_hc     <= '0;
      r_vc     <= '0;
      r_hsync  <= ~H_POL;
      r_vsync  <= ~V_POL;
      r_active <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_ls     <= 1'b0;
      r_fs     <= 1'b0;
    end else if (pix_en) begin
      r_hc     <= w_hc_nxt;
      r_vc     <= w_vc_nxt;
      r_hsync  <= w_h_sync ? H_POL : ~H_POL;
      r_vsync  <= w_v_sync ? V_POL : ~V_POL;
      r_active <= w_active;
      r_x      <= w_active ? r_hc - C_H_BL : '0;
      r_y      <= w_active ? r_vc - C_V_BL : '0;
      r_ls     <= w_line0;
      r_fs     <= w_frame0;
    end else begin
      // Everything else holds; strobes must never stretch across idle cycles.
      r_ls     <= 1'b0;
      r_fs     <= 1'b0;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_fcnt;
  always_ff @(posedge px_clk) begin
    if (reset)
      r_fcnt <= '0;
    else if (pix_en && w_frame0)
      r_fcnt <= r_fcnt + 16'd1;
  end
  assign frame_cnt = r_fcnt;
`endif

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign activevideo = r_active;
  assign x_px        = r_x;
  assign y_px        = r_y;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule
